param_fifo_arb: RTL and testbench

PARAM_FIFO_ARB -- requirements
Module: param_fifo_arb

---
 rtl/param_arb_pkg.sv | 29 ++
 rtl/param_arb_wdog.sv | 28 ++
 rtl/param_fifo_arb.sv | 148 ++++++++++++++
 tb/tb_param_fifo_arb.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/param_arb_pkg.sv
// Shared types and defaults for the parameter-FIFO arbiter between the
// auto-load and JTAG readback requesters.
package param_arb_pkg;

  localparam int unsigned LEN_W  = 6;
  localparam int unsigned WDOG_W = 8;

  localparam logic [LEN_W-1:0]  MAX_LEN_DEF = 6'd36;
  localparam logic [WDOG_W-1:0] TIMEOUT_DEF = 8'd255;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_A = 2'd1,
    ST_GRANT_B = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic             req;
    logic [LEN_W-1:0] len;
    logic             rd;
  } req_s;

  // A request is only worth granting with a non-empty, in-range burst.
  function automatic logic req_eligible(input req_s r, input logic [LEN_W-1:0] max_len);
    return r.req && (r.len != '0) && (r.len <= max_len);
  endfunction

endpackage

// File: rtl/param_arb_wdog.sv
// Clearable idle-cycle watchdog; flags the cycle whose count would reach TERM.
module param_arb_wdog
  import param_arb_pkg::*;
#(
  parameter logic [WDOG_W-1:0] TERM = TIMEOUT_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_c_o
);

  logic [WDOG_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + WDOG_W'(1);
    end
  end

  assign tc_c_o = en_i & ~clr_i & (cnt_q == (TERM - WDOG_W'(1)));

endmodule

// File: rtl/param_fifo_arb.sv
// Arbitrates parameter-FIFO bursts between auto-load (A) and JTAG readback (B)
// with alternating priority, per-grant word counting and an idle watchdog.
module param_fifo_arb
  import param_arb_pkg::*;
#(
  parameter logic [LEN_W-1:0]  MAX_LEN = MAX_LEN_DEF,
  parameter logic [WDOG_W-1:0] TIMEOUT = TIMEOUT_DEF
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             A_REQ,
  input  logic [LEN_W-1:0] A_LEN,
  input  logic             A_RD,
  output logic             A_GNT,
  output logic             A_DONE,
  input  logic             B_REQ,
  input  logic [LEN_W-1:0] B_LEN,
  input  logic             B_RD,
  output logic             B_GNT,
  output logic             B_DONE,
  input  logic             FIFO_EMPTY,
  output logic             FIFO_RD,
  output logic             ABORT,
  output logic             UNDERRUN,
  output logic [1:0]       ARB_STATE,
  output logic [LEN_W-1:0] WCNT
);

  arb_state_e       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] wcnt_q, wcnt_d;
  logic             last_a_q, last_a_d;
  logic             gnt_a_q, gnt_b_q;
  logic             done_a_q, done_a_d;
  logic             done_b_q, done_b_d;
  logic             abort_q, abort_d;
  logic             underrun_q;

  req_s req_a, req_b;
  logic elig_a_c, elig_b_c;
  logic strobe_c, rd_c, in_grant_c, cur_req_c, final_c, wdog_tc_c;

  assign req_a = '{req: A_REQ, len: A_LEN, rd: A_RD};
  assign req_b = '{req: B_REQ, len: B_LEN, rd: B_RD};

  assign elig_a_c   = req_eligible(req_a, MAX_LEN);
  assign elig_b_c   = req_eligible(req_b, MAX_LEN);
  assign strobe_c   = (gnt_a_q & req_a.rd) | (gnt_b_q & req_b.rd);
  assign rd_c       = strobe_c & ~FIFO_EMPTY;
  assign in_grant_c = (state_q == ST_GRANT_A) || (state_q == ST_GRANT_B);
  assign cur_req_c  = (state_q == ST_GRANT_A) ? req_a.req : req_b.req;
  assign final_c    = rd_c && ((wcnt_q + LEN_W'(1)) == len_q);

  // Any read, or being outside a grant, keeps the watchdog at zero.
  param_arb_wdog #(
    .TERM (TIMEOUT)
  ) u_wdog (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .clr_i  (rd_c | ~in_grant_c),
    .en_i   (in_grant_c),
    .tc_c_o (wdog_tc_c)
  );

  always_comb begin
    state_d  = arb_state_e'(2'bxx);
    len_d    = len_q;
    wcnt_d   = wcnt_q;
    last_a_d = last_a_q;
    done_a_d = 1'b0;
    done_b_d = 1'b0;
    abort_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (elig_a_c && !(last_a_q && elig_b_c)) begin
          state_d  = ST_GRANT_A;
          len_d    = req_a.len;
          wcnt_d   = '0;
          last_a_d = 1'b1;
        end else if (elig_b_c) begin
          state_d  = ST_GRANT_B;
          len_d    = req_b.len;
          wcnt_d   = '0;
          last_a_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT_A, ST_GRANT_B: begin
        state_d = state_q;
        if (rd_c) begin
          wcnt_d = wcnt_q + LEN_W'(1);
        end
        // Final read outranks a dropped request and the watchdog.
        if (final_c) begin
          state_d  = ST_RELEASE;
          done_a_d = (state_q == ST_GRANT_A);
          done_b_d = (state_q == ST_GRANT_B);
        end else if (!cur_req_c) begin
          state_d = ST_RELEASE;
        end else if (wdog_tc_c) begin
          state_d = ST_RELEASE;
          abort_d = 1'b1;
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      wcnt_q     <= '0;
      last_a_q   <= 1'b0;
      gnt_a_q    <= 1'b0;
      gnt_b_q    <= 1'b0;
      done_a_q   <= 1'b0;
      done_b_q   <= 1'b0;
      abort_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      wcnt_q     <= wcnt_d;
      last_a_q   <= last_a_d;
      gnt_a_q    <= (state_d == ST_GRANT_A);
      gnt_b_q    <= (state_d == ST_GRANT_B);
      done_a_q   <= done_a_d;
      done_b_q   <= done_b_d;
      abort_q    <= abort_d;
      underrun_q <= strobe_c & FIFO_EMPTY;
    end
  end

  assign FIFO_RD   = rd_c;
  assign A_GNT     = gnt_a_q;
  assign B_GNT     = gnt_b_q;
  assign A_DONE    = done_a_q;
  assign B_DONE    = done_b_q;
  assign ABORT     = abort_q;
  assign UNDERRUN  = underrun_q;
  assign ARB_STATE = state_q;
  assign WCNT      = wcnt_q;

endmodule

// File: tb/tb_param_fifo_arb.sv
// Directed bench for param_fifo_arb: bursts, alternation, underrun, timeout,
// reset mid-burst and length boundaries.
module tb_param_fifo_arb;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       A_REQ, A_RD, B_REQ, B_RD, FIFO_EMPTY;
  logic [5:0] A_LEN, B_LEN;
  logic       A_GNT, A_DONE, B_GNT, B_DONE, FIFO_RD, ABORT, UNDERRUN;
  logic [1:0] ARB_STATE;
  logic [5:0] WCNT;

  int n_checks = 0;
  int n_errors = 0;

  param_fifo_arb dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .A_REQ      (A_REQ),
    .A_LEN      (A_LEN),
    .A_RD       (A_RD),
    .A_GNT      (A_GNT),
    .A_DONE     (A_DONE),
    .B_REQ      (B_REQ),
    .B_LEN      (B_LEN),
    .B_RD       (B_RD),
    .B_GNT      (B_GNT),
    .B_DONE     (B_DONE),
    .FIFO_EMPTY (FIFO_EMPTY),
    .FIFO_RD    (FIFO_RD),
    .ABORT      (ABORT),
    .UNDERRUN   (UNDERRUN),
    .ARB_STATE  (ARB_STATE),
    .WCNT       (WCNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int rd_cnt, done_cnt, und_cnt, abort_cnt, busy_cnt;
    logic [6:0] empty_pat;

    RST_N = 1'b0; A_REQ = 0; A_RD = 0; A_LEN = '0;
    B_REQ = 0; B_RD = 0; B_LEN = '0; FIFO_EMPTY = 0;
    #1;
    check("rst_state", 32'(ARB_STATE), 0);
    check("rst_gnts", 32'({A_GNT, B_GNT}), 0);
    check("rst_pulses", 32'({A_DONE, B_DONE, ABORT, UNDERRUN}), 0);
    check("rst_wcnt", 32'(WCNT), 0);
    step(); step();
    RST_N = 1'b1;

    // 34-word auto-load burst
    A_REQ = 1; A_LEN = 6'd34; A_RD = 1;
    step();
    check("t1_gnt", 32'({A_GNT, B_GNT}), 2);
    check("t1_state", 32'(ARB_STATE), 1);
    check("t1_wcnt0", 32'(WCNT), 0);
    rd_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 34; i++) begin
      rd_cnt += int'(FIFO_RD);
      done_cnt += int'(A_DONE);
      step();
    end
    check("t1_rd_pulses", 32'(rd_cnt), 34);
    check("t1_early_done", 32'(done_cnt), 0);
    check("t1_release", 32'(ARB_STATE), 3);
    check("t1_done", 32'(A_DONE), 1);
    check("t1_wcnt", 32'(WCNT), 34);
    check("t1_gnt_rel", 32'({A_GNT, B_GNT, FIFO_RD}), 0);
    A_REQ = 0; A_RD = 0;
    step();
    check("t1_idle", 32'(ARB_STATE), 0);
    check("t1_done_off", 32'(A_DONE), 0);

    // Both request from reset: A first, then B
    RST_N = 0; #1; RST_N = 1;
    A_REQ = 1; A_LEN = 6'd2; A_RD = 1;
    B_REQ = 1; B_LEN = 6'd3; B_RD = 0;
    step();
    check("t2_a_first", 32'({A_GNT, B_GNT}), 2);
    step();
    check("t2_wcnt1", 32'(WCNT), 1);
    step();
    check("t2_a_release", 32'({ARB_STATE, A_DONE, B_GNT}), 32'b1110);
    step();
    check("t2_gap_idle", 32'({ARB_STATE, A_GNT, B_GNT}), 0);
    step();
    check("t2_b_next", 32'({A_GNT, B_GNT}), 1);
    check("t2_state_b", 32'(ARB_STATE), 2);
    check("t2_other_rd", 32'(FIFO_RD), 0);
    B_RD = 1; A_RD = 0;
    step(); step(); step();
    check("t2_b_done", 32'({ARB_STATE, B_DONE}), 32'b111);
    check("t2_b_wcnt", 32'(WCNT), 3);
    step();
    check("t2_idle2", 32'(ARB_STATE), 0);
    step();
    check("t2_a_again", 32'({A_GNT, B_GNT}), 2);
    A_REQ = 0; B_RD = 0;
    step();
    check("t2_drop_rel", 32'(ARB_STATE), 3);
    check("t2_drop_nodone", 32'({A_DONE, ABORT}), 0);
    B_REQ = 0;
    step();
    check("t2_idle3", 32'(ARB_STATE), 0);

    // Underrun while B holds the grant
    B_REQ = 1; B_LEN = 6'd4; B_RD = 1;
    step();
    check("t3_b_gnt", 32'({A_GNT, B_GNT}), 1);
    empty_pat = 7'b0001110;
    rd_cnt = 0; und_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) step();
      FIFO_EMPTY = empty_pat[i];
      #1;
      rd_cnt += int'(FIFO_RD);
      und_cnt += int'(UNDERRUN);
      if (i == 4) check("t3_wcnt_hold", 32'(WCNT), 1);
    end
    check("t3_rd_cnt", 32'(rd_cnt), 4);
    check("t3_underruns", 32'(und_cnt), 3);
    step();
    check("t3_done", 32'({ARB_STATE, B_DONE}), 32'b111);
    check("t3_wcnt", 32'(WCNT), 4);
    B_REQ = 0; B_RD = 0;
    step();
    check("t3_idle", 32'({ARB_STATE, UNDERRUN}), 0);

    // Watchdog abort after reads stop
    A_REQ = 1; A_LEN = 6'd10; A_RD = 1;
    step();
    check("t4_gnt", 32'(A_GNT), 1);
    step();
    step();
    A_RD = 0;
    check("t4_wcnt", 32'(WCNT), 2);
    abort_cnt = 0; busy_cnt = 0;
    for (int j = 0; j < 254; j++) begin
      step();
      abort_cnt += int'(ABORT);
      busy_cnt += int'(ARB_STATE == 2'd1);
    end
    check("t4_no_early_abort", 32'(abort_cnt), 0);
    check("t4_held", 32'(busy_cnt), 254);
    step();
    check("t4_abort", 32'({ARB_STATE, ABORT, A_DONE}), 32'b1110);
    check("t4_wcnt_kept", 32'(WCNT), 2);
    A_REQ = 0;
    step();
    check("t4_idle", 32'({ARB_STATE, ABORT}), 0);

    // Final read coincides with request drop
    A_REQ = 1; A_LEN = 6'd1; A_RD = 1;
    step();
    A_REQ = 0;
    #1;
    check("t5_final_rd", 32'(FIFO_RD), 1);
    step();
    check("t5_done_wins", 32'({ARB_STATE, A_DONE, ABORT}), 32'b1110);
    A_RD = 0;
    step();

    // Reset in the middle of a burst
    A_REQ = 1; A_LEN = 6'd10; A_RD = 1;
    step();
    repeat (5) step();
    check("t6_wcnt5", 32'(WCNT), 5);
    #2;
    RST_N = 0;
    #1;
    check("t6_async_gnt", 32'({A_GNT, FIFO_RD}), 0);
    check("t6_async_wcnt", 32'(WCNT), 0);
    check("t6_async_state", 32'(ARB_STATE), 0);
    A_LEN = 6'd0;
    #1;
    RST_N = 1;
    busy_cnt = 0;
    repeat (3) begin
      step();
      busy_cnt += int'(ARB_STATE != 2'd0) + int'(A_GNT);
    end
    check("t6_len0_ignored", 32'(busy_cnt), 0);
    A_LEN = 6'd37;
    step(); step();
    check("t6_len37_ignored", 32'({ARB_STATE, A_GNT}), 0);
    A_LEN = 6'd36;
    step();
    check("t6_len36_granted", 32'({ARB_STATE, A_GNT}), 32'b011);
    A_REQ = 0; A_RD = 0;
    step(); step();
    check("t6_end_idle", 32'(ARB_STATE), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
